// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave frame receiver feeding a WS2812 LED driver.
// Collects exactly NUM_LEDS*BITS_PER_LED bits per chip-select window and
// publishes them on a parallel bus with a one-cycle data_rdy strobe.
// Short, empty and oversized frames are dropped and flagged with frame_err.
// NUM_LEDS*BITS_PER_LED is expected to be a multiple of 8.
module spi_frame_rx #(
   parameter int NUM_LEDS     = 3,
   parameter int BITS_PER_LED = 24
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             sclk,
   input  logic                             mosi,
   input  logic                             cs_n,
   output logic [NUM_LEDS*BITS_PER_LED-1:0] data,
   output logic                             data_rdy,
   output logic                             frame_err
);

   localparam int FRAME_BITS = NUM_LEDS * BITS_PER_LED;
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

   typedef enum logic {IDLE, RECV} state_t;

   logic [1:0]            sclk_sync_reg;
   logic [1:0]            cs_sync_reg;
   logic [1:0]            mosi_sync_reg;
   logic                  sclk_prev_reg;
   logic                  cs_prev_reg;
   logic                  sclk_rise_reg;
   logic                  cs_rise_reg;
   logic                  cs_fall_reg;
   logic                  mosi_bit_reg;
   logic [1:0]            flush_cnt_reg;
   logic                  armed_reg;
   state_t                state_reg;
   logic [CNT_W-1:0]      bit_cnt_reg;
   logic [FRAME_BITS-1:0] shift_reg;

   // Two-stage synchronizers, reset to the SPI idle levels.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_reg <= 2'b00;
         cs_sync_reg   <= 2'b11;
         mosi_sync_reg <= 2'b00;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[0], sclk};
         cs_sync_reg   <= {cs_sync_reg[0], cs_n};
         mosi_sync_reg <= {mosi_sync_reg[0], mosi};
      end
   end

   // Registered edge detection; mosi is retimed alongside so the captured
   // bit is the one sampled together with the sclk rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_prev_reg <= 1'b0;
         cs_prev_reg   <= 1'b1;
         sclk_rise_reg <= 1'b0;
         cs_rise_reg   <= 1'b0;
         cs_fall_reg   <= 1'b0;
         mosi_bit_reg  <= 1'b0;
      end else begin
         sclk_prev_reg <= sclk_sync_reg[1];
         cs_prev_reg   <= cs_sync_reg[1];
         sclk_rise_reg <= sclk_sync_reg[1] & ~sclk_prev_reg;
         cs_rise_reg   <= cs_sync_reg[1] & ~cs_prev_reg;
         cs_fall_reg   <= ~cs_sync_reg[1] & cs_prev_reg;
         mosi_bit_reg  <= mosi_sync_reg[1];
      end
   end

   // A reset while cs_n is held low would otherwise look like a fresh
   // falling edge once the synchronizers flush; only arm frame start after
   // cs_n has genuinely been observed high following reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_cnt_reg <= 2'd0;
         armed_reg     <= 1'b0;
      end else begin
         if (flush_cnt_reg != 2'd3) begin
            flush_cnt_reg <= flush_cnt_reg + 2'd1;
         end else if (cs_prev_reg) begin
            armed_reg <= 1'b1;
         end
      end
   end

   // Frame FSM: shift bits while selected, validate length on deselect.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         data        <= '0;
         data_rdy    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         data_rdy  <= 1'b0;
         frame_err <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cs_fall_reg && armed_reg) begin
                  state_reg   <= RECV;
                  bit_cnt_reg <= '0;
                  shift_reg   <= '0;
               end
            end
            RECV: begin
               // Deselect wins over a coincident sclk rise.
               if (cs_rise_reg) begin
                  state_reg <= IDLE;
                  if (bit_cnt_reg == CNT_FULL) begin
                     data     <= shift_reg;
                     data_rdy <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else if (sclk_rise_reg) begin
                  shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_bit_reg};
                  if (bit_cnt_reg != CNT_SAT) begin
                     bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: each chip-select window pushes the
// expected outcome, a negedge monitor pops and checks it when a strobe fires.
module tb_spi_frame_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sclk = 1'b0;
   logic        mosi = 1'b0;
   logic        cs_n = 1'b1;
   logic [71:0] data;
   logic        data_rdy;
   logic        frame_err;

   typedef struct {
      logic        kind;   // 0 = data_rdy, 1 = frame_err
      logic [71:0] d;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [71:0] model_data = '0;

   spi_frame_rx #(.NUM_LEDS(3), .BITS_PER_LED(24)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .data(data), .data_rdy(data_rdy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         mosi = b[i];
         tick(4);
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
   endtask

   // One chip-select window of n bytes: first, first+step, ...
   task automatic frame(input int n, input logic [7:0] first, input logic [7:0] step, input int gap);
      logic [71:0] acc;
      logic [7:0]  b;
      exp_t        e;
      acc = '0;
      b = first;
      cs_n = 1'b0;
      tick(4);
      for (int i = 0; i < n; i++) begin
         spi_byte(b);
         if (i < 9) acc = {acc[63:0], b};
         b = b + step;
      end
      tick(6);
      cs_n = 1'b1;
      if (n == 9) begin
         model_data = acc;
         e.kind = 1'b0;
      end else begin
         e.kind = 1'b1;
      end
      e.d = model_data;
      e.cyc = cyc + 4;
      sb.push_back(e);
      tick(gap);
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset && (data_rdy || frame_err)) begin
         exp_t e;
         check("both_strobes", {71'b0, data_rdy & frame_err}, 72'd0);
         if (sb.size() == 0) begin
            check("unexpected_strobe", {70'b0, data_rdy, frame_err}, 72'd0);
         end else begin
            e = sb.pop_front();
            $display("txn cyc=%0d rdy=%0b err=%0b data=%h", cyc, data_rdy, frame_err, data);
            check("kind", {71'b0, frame_err}, {71'b0, e.kind});
            check("data", data, e.d);
            check("latency", 72'(cyc), 72'(e.cyc));
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      tick(3);
      check("rst_data", data, 72'd0);
      check("rst_rdy", {71'b0, data_rdy}, 72'd0);
      check("rst_err", {71'b0, frame_err}, 72'd0);
      reset = 1'b0;
      tick(10);

      // Nominal, short, overrun, long overrun.
      frame(9, 8'h11, 8'h11, 8);
      check("nominal_hold", data, 72'h112233445566778899);
      frame(8, 8'hFF, 8'h00, 8);
      check("short_hold", data, 72'h112233445566778899);
      frame(10, 8'hAA, 8'h00, 8);
      check("overrun_hold", data, 72'h112233445566778899);
      frame(265, 8'h5A, 8'h01, 8);
      check("sat_hold", data, 72'h112233445566778899);

      // Reset mid-frame: no strobe, data cleared.
      cs_n = 1'b0;
      tick(4);
      for (int i = 0; i < 5; i++) spi_byte(8'hC3);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(4);
      cs_n = 1'b1;
      tick(10);
      model_data = '0;
      check("midrst_data", data, 72'd0);
      check("midrst_pending", 72'(sb.size()), 72'd0);
      frame(9, 8'h01, 8'h01, 8);
      check("after_rst", data, 72'h010203040506070809);

      // Idle noise with cs_n high.
      for (int i = 0; i < 100; i++) begin
         mosi = 1'($urandom_range(0, 1));
         sclk = ~sclk;
         tick(4);
      end
      tick(8);
      check("noise_data", data, 72'h010203040506070809);

      // Back-to-back frames with 3 clk of cs_n high between them.
      frame(9, 8'h21, 8'h03, 3);
      frame(9, 8'hF0, 8'hFF, 8);
      check("b2b_data", data, 72'hF0EFEEEDECEBEAE9E8);

      // Empty select.
      frame(0, 8'h00, 8'h00, 8);
      check("empty_hold", data, 72'hF0EFEEEDECEBEAE9E8);

      tick(10);
      check("sb_empty", 72'(sb.size()), 72'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
